// File: rtl/core_fetch_queue.sv
// rtl/core_fetch_queue.sv - DEPTH-entry instruction prefetch queue with pipelined bus reads
module core_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [XLEN-1:0]            i_boot_addr,
    input  logic                       i_redirect,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [XLEN-1:0]            o_pc,
    output logic [XLEN-1:0]            o_next_pc,
    output logic [31:0]                o_instr,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_rd_req,
    output logic [XLEN-1:0]            o_rd_addr,
    input  logic                       i_rd_gnt,
    input  logic [31:0]                i_rd_data
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int OCC_W = CW + 1;

    typedef enum logic {S_BOOT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic [XLEN-1:0]   pc_mem_q [DEPTH];
    logic [31:0]       instr_mem_q [DEPTH];

    logic              rd_req;
    logic              accept;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    // An in-flight read already owns a slot, so requests stop one entry early.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        fpc_d         = fpc_q;
        rd_req        = 1'b0;
        accept        = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                fpc_d   = i_boot_addr & ~XLEN'(3);
                state_d = S_RUN;
            end
            S_RUN: begin
                rd_req = ~i_redirect && (occupancy < OCC_W'(DEPTH));
                accept = rd_req & i_rd_gnt;
                if (i_redirect) begin
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    inflight_d = 1'b0;
                    fpc_d      = i_redirect_pc & ~XLEN'(3);
                end else begin
                    push       = inflight_q;
                    pop        = (count_q != '0) & i_ready;
                    inflight_d = accept;
                    if (accept) begin
                        fpc_d         = fpc_q + XLEN'(4);
                        inflight_pc_d = fpc_q;
                    end
                    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fpc_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fpc_q         <= fpc_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
                instr_mem_q[wr_ptr_q] <= i_rd_data;
            end
        end
    end

    // Head is read straight from storage; no bypass from the returning read.
    assign o_valid   = (count_q != '0);
    assign o_pc      = pc_mem_q[rd_ptr_q];
    assign o_instr   = instr_mem_q[rd_ptr_q];
    assign o_next_pc = o_pc + XLEN'(4);
    assign o_count   = count_q;
    assign o_rd_req  = rd_req;
    assign o_rd_addr = fpc_q;

endmodule

// File: doc/core_fetch_queue.md
Name: core_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RV32I pipeline core. It replaces the single-entry fetch/ID segment register with a DEPTH-entry prefetch queue. The queue issues pipelined word reads on the instruction bus, buffers {pc, instr} pairs, and hands them to the ID stage under a valid/ready handshake. A redirect from EX or ID flushes the queue and any in-flight fetch.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
DEPTH, 4, number of queue entries; must be a power of two, 2 to 16.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_boot_addr  in  XLEN  first fetch address; sampled in the first cycle after reset release
i_redirect  in  1  flush the queue and restart fetch at i_redirect_pc
i_redirect_pc  in  XLEN  redirect target; bits[1:0] are ignored and treated as 0
o_valid  out  1  queue head holds a valid instruction
i_ready  in  1  ID stage accepts the head this cycle
o_pc  out  XLEN  head instruction address
o_next_pc  out  XLEN  o_pc + 4
o_instr  out  32  head instruction word
o_count  out  clog2(DEPTH+1)  current queue occupancy
o_rd_req  out  1  instruction bus read request
o_rd_addr  out  XLEN  instruction bus word address; bits[1:0] always 0
i_rd_gnt  in  1  bus accepts the request this cycle
i_rd_data  in  32  read data; valid exactly one cycle after an accepted request

Behaviour:
- Reset: asynchronous, active-low. Clears:
  - state to S_BOOT
  - count, rd/wr pointers, inflight to 0
  - fpc to 0
  - all queue entries to 0
- Outputs during reset: o_valid=0, o_rd_req=0, o_count=0, o_pc=0, o_instr=0, o_next_pc=4.
- State machine:
  - S_BOOT: o_rd_req=0; fpc<=i_boot_addr&~3; go to S_RUN next cycle.
  - S_RUN: normal operation; the block never leaves S_RUN except through reset.
- Request rule, S_RUN: o_rd_req = ~i_redirect & (count + inflight < DEPTH); o_rd_addr = fpc.
- Accept: accept = o_rd_req & i_rd_gnt.
  - On accept: fpc <= fpc + 4 (wraps modulo 2^32); inflight <= 1; the accepted address is captured as inflight_pc.
  - Otherwise inflight <= 0.
- Bus stall: while o_rd_req=1 and i_rd_gnt=0, o_rd_addr stays stable. The only exception is a redirect, which deasserts the request.
- Push: when inflight=1 and i_redirect=0, {inflight_pc, i_rd_data} is written at the write pointer; count increments.
- Pop: when o_valid & i_ready & ~i_redirect, the read pointer advances; count decrements.
- Push and pop in the same cycle leave count unchanged. Push never overflows, because the request rule reserves the slot.
- Head outputs: o_valid = (count != 0). o_pc and o_instr come from the entry at the read pointer, with no fall-through bypass. With count=0 they show the stale entry; consumers must qualify with o_valid.
- Redirect (highest priority, any S_RUN cycle):
  - count, both pointers and inflight are cleared.
  - fpc <= i_redirect_pc & ~3.
  - o_rd_req=0 in that same cycle.
  - Read data arriving in that cycle is discarded.
  - Any pop in that cycle is ignored.
- Redirect latency: redirect in cycle N; request to the target in N+1. If granted in N+1, data is pushed at the end of N+2 and o_valid=1 in N+3.
- Boot latency: reset released before edge 0; request at boot address in cycle 1. With immediate grant, o_valid=1 in cycle 3.
- Throughput: one instruction per cycle sustained when i_rd_gnt and i_ready are held high.
- Redirect during S_BOOT is ignored.
- Reset mid-transfer: all state clears asynchronously; a later i_rd_data return is ignored because inflight=0.

Test Plan:
- Boot: i_boot_addr=0x0000_0100, gnt=1, ready=1. Required: o_rd_addr sequence 0x100, 0x104, 0x108 …; o_valid=1 from cycle 3 with o_pc=0x100; o_next_pc=0x104; then one instruction per cycle.
- Fill/full: DEPTH=4, ready=0, gnt=1. Required: exactly 4 accepted requests (0x100–0x10C); o_count=4; o_rd_req=0 thereafter. Then ready=1 for 1 cycle: o_rd_req reasserts with addr 0x110; o_count stays ≤4.
- Bus wait states: gnt=0 for 3 cycles on addr 0x104. Required: o_rd_req=1 and o_rd_addr=0x104 stable for all 3 cycles; no push; the instruction appears after gnt with correct data.
- Redirect with queue at count=3 and inflight=1, i_redirect_pc=0x2002. Required: next cycle o_count=0, o_valid=0; the in-flight data is dropped; the next request goes to 0x2000; the first valid o_pc is 0x2000.
- Redirect while ready=1 and a push coincide: same-cycle pop, push and redirect. Required: only the redirect takes effect; o_count=0 next cycle.
- Wrap and reset: redirect to 0xFFFF_FFFC. Required: addresses 0xFFFF_FFFC then 0x0000_0000. Assert rst_n=0 mid-stream: all outputs return to reset values immediately.
